hr_bridge_fifo: RTL and testbench

Synchronous first-word-fall-through flit queue that sits between a ring stop and the HRbridge transfer path. It buffers flits that cross between local and global rings. It presents the head flit and a registered `bfull_o` (back-pressure signal) to the bridge. It accepts the bridge's `enQ`/`deQ` strobes. One instance sits on each of the six bridge ports (l0, l1, g0–g3).

---
 rtl/hr_bridge_fifo.sv | 80 ++++++++
 tb/tb_hr_bridge_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hr_bridge_fifo.sv
// First-word-fall-through flit queue between a ring stop and the HRbridge transfer path.
// The head flit is read combinationally; bfull_o is registered from next-cycle occupancy.
module hr_bridge_fifo #(
    parameter int DATA_W      = 144,
    parameter int DEPTH       = 8,
    parameter int FULL_MARGIN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    enQ_i,
    input  logic                    deQ_i,
    output logic [DATA_W-1:0]       data_o,
    output logic                    empty_o,
    output logic                    bfull_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    ovf_o,
    output logic                    udf_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_TH = CW'(DEPTH - FULL_MARGIN);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rp;
    logic [AW-1:0]     wp;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic              acc_enq;
    logic              acc_deq;

    // A full queue still takes a flit when the head leaves in the same cycle.
    always_comb begin
        acc_deq  = deQ_i && (cnt != '0);
        acc_enq  = enQ_i && ((cnt != DEPTH_C) || acc_deq);
        cnt_next = cnt;
        if (acc_enq && !acc_deq) begin
            cnt_next = cnt + CNT_ONE;
        end else if (!acc_enq && acc_deq) begin
            cnt_next = cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp      <= '0;
            wp      <= '0;
            cnt     <= '0;
            bfull_o <= 1'b0;
            ovf_o   <= 1'b0;
            udf_o   <= 1'b0;
        end else begin
            if (acc_enq) begin
                wp <= wp + PTR_ONE;
            end
            if (acc_deq) begin
                rp <= rp + PTR_ONE;
            end
            cnt     <= cnt_next;
            bfull_o <= (cnt_next >= FULL_TH);
            ovf_o   <= ovf_o | (enQ_i && !acc_enq);
            udf_o   <= udf_o | (deQ_i && (cnt == '0));
        end
    end

    // Storage carries no reset; validity is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (acc_enq && !rst) begin
            mem[wp] <= data_i;
        end
    end

    assign data_o  = (cnt == '0) ? '0 : mem[rp];
    assign empty_o = (cnt == '0);
    assign count_o = cnt;

endmodule

// File: tb/tb_hr_bridge_fifo.sv
// Scoreboard bench for hr_bridge_fifo: stimulus pushes accepted flits, a monitor
// pops and compares the head whenever the DUT performs a dequeue.
module tb_hr_bridge_fifo;
    localparam int DATA_W      = 144;
    localparam int DEPTH       = 8;
    localparam int FULL_MARGIN = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] data_i = '0;
    logic              enQ_i = 1'b0;
    logic              deQ_i = 1'b0;
    logic [DATA_W-1:0] data_o;
    logic              empty_o;
    logic              bfull_o;
    logic [3:0]        count_o;
    logic              ovf_o;
    logic              udf_o;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                mcnt = 0;
    bit                movf = 1'b0;
    bit                mudf = 1'b0;

    hr_bridge_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .FULL_MARGIN(FULL_MARGIN)
    ) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .enQ_i(enQ_i), .deQ_i(deQ_i),
        .data_o(data_o), .empty_o(empty_o), .bfull_o(bfull_o), .count_o(count_o),
        .ovf_o(ovf_o), .udf_o(udf_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] flit(input int n);
        logic [127:0] mid;
        mid = 128'h0123_4567_89ab_cdef_ffff_ffff_ffff_185f;
        return {8'(n), mid, 8'(n)};
    endfunction

    function automatic void chk(input string name, input logic [DATA_W-1:0] got,
                                input logic [DATA_W-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endfunction

    // Monitor: every real dequeue must present the oldest expected flit.
    always @(posedge clk) begin
        if (!rst && deQ_i && !empty_o) begin
            if (exp_q.size() == 0) begin
                chk("deq_unexpected", data_o, '0);
                checks++;
                failures++;
                $display("FAIL deq_scoreboard got=%h want=<none>", data_o);
            end else begin
                chk("deq_head", data_o, exp_q.pop_front());
            end
        end
    end

    task automatic check_state(input string tag);
        logic [DATA_W-1:0] head;
        head = (mcnt == 0 || exp_q.size() == 0) ? '0 : exp_q[0];
        chk({tag, ":count"}, DATA_W'(count_o), DATA_W'(mcnt));
        chk({tag, ":empty"}, DATA_W'(empty_o), DATA_W'(mcnt == 0));
        chk({tag, ":bfull"}, DATA_W'(bfull_o), DATA_W'(mcnt >= DEPTH - FULL_MARGIN));
        chk({tag, ":ovf"},   DATA_W'(ovf_o),   DATA_W'(movf));
        chk({tag, ":udf"},   DATA_W'(udf_o),   DATA_W'(mudf));
        chk({tag, ":head"},  data_o, head);
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic step(input bit e, input bit d, input logic [DATA_W-1:0] dat,
                        input string tag);
        bit ad, ae;
        enQ_i  = e;
        deQ_i  = d;
        data_i = dat;
        ad = d && (mcnt > 0);
        ae = e && ((mcnt < DEPTH) || ad);
        if (ae) exp_q.push_back(dat);
        if (e && !ae) movf = 1'b1;
        if (d && mcnt == 0) mudf = 1'b1;
        mcnt = mcnt + int'(ae) - int'(ad);
        @(negedge clk);
        enQ_i = 1'b0;
        deQ_i = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enQ_i  = 1'b1;
        deQ_i  = 1'b0;
        data_i = 144'h0123_4567_89ab_cdef_0000_1111_2222_ffff_185f;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        enQ_i = 1'b0;
        exp_q.delete();
        mcnt = 0;
        movf = 1'b0;
        mudf = 1'b0;
        check_state("reset");
    endtask

    initial begin
        do_reset();
        chk("reset_data_zero", data_o, '0);

        // Fill and back-pressure
        for (int i = 1; i <= 7; i++) step(1, 0, flit(i), "fill");
        chk("fill7_count", DATA_W'(count_o), DATA_W'(7));
        chk("fill7_bfull", DATA_W'(bfull_o), DATA_W'(1));
        chk("fill7_head", data_o, flit(1));
        step(1, 0, flit(8), "fill8");
        chk("fill8_ovf", DATA_W'(ovf_o), DATA_W'(0));
        step(1, 0, flit(9), "fill9_drop");
        chk("fill9_ovf", DATA_W'(ovf_o), DATA_W'(1));
        chk("fill9_count", DATA_W'(count_o), DATA_W'(8));

        // Drain in order; bfull drops when occupancy falls to 6
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, '0, "drain");
            if (i == 1) chk("drain1_bfull", DATA_W'(bfull_o), DATA_W'(1));
            if (i == 2) chk("drain2_bfull", DATA_W'(bfull_o), DATA_W'(0));
        end
        chk("drained_empty", DATA_W'(empty_o), DATA_W'(1));
        chk("drained_data", data_o, '0);
        for (int i = 10; i <= 12; i++) step(1, 0, flit(i), "wrap_fill");
        chk("wrap_head", data_o, flit(10));
        for (int i = 0; i < 3; i++) step(0, 1, '0, "wrap_drain");

        // Simultaneous enqueue/dequeue at full, with wrapped pointers
        do_reset();
        for (int i = 20; i < 28; i++) step(1, 0, flit(i), "full_fill");
        for (int i = 28; i < 32; i++) begin
            step(1, 1, flit(i), "full_both");
            chk("full_both_count", DATA_W'(count_o), DATA_W'(8));
        end
        chk("full_both_ovf", DATA_W'(ovf_o), DATA_W'(0));
        chk("full_both_head", data_o, flit(24));
        for (int i = 0; i < 8; i++) step(0, 1, '0, "full_drain");

        // Simultaneous at empty: enqueue lands, dequeue flagged
        step(1, 1, flit(40), "empty_both");
        chk("empty_both_count", DATA_W'(count_o), DATA_W'(1));
        chk("empty_both_udf", DATA_W'(udf_o), DATA_W'(1));
        chk("empty_both_head", data_o, flit(40));
        step(0, 1, '0, "pop_last");

        // Underflow on empty; flag sticks
        step(0, 1, '0, "underflow");
        chk("udf_data", data_o, '0);
        step(0, 0, '0, "udf_hold");
        chk("udf_sticky", DATA_W'(udf_o), DATA_W'(1));

        // Random traffic against the scoreboard
        do_reset();
        for (int i = 0; i < 100; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), flit(100 + i), "rand");
        while (mcnt > 0) step(0, 1, '0, "final_drain");
        chk("final_empty", DATA_W'(empty_o), DATA_W'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
